reg_file: RTL and testbench

//   General-purpose register file of the 16-bit RISC datapath; sits directly

---
 rtl/reg_file.sv | 93 +++++++++
 tb/tb_reg_file.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: general-purpose register file of the 16-bit RISC datapath.
//   Two combinational read ports feed ALU operands a/b. One synchronous write
//   port takes writeback data. Optional write-to-read bypass.
// Ports:
//   clk                 rising-edge clock
//   rst                 async active-high reset, clears every register
//   rd_addr1/rd_data1   read port 1 (ALU a)
//   rd_addr2/rd_data2   read port 2 (ALU b)
//   wr_en/wr_addr/wr_data  write port, sampled on rising clk

// One read port. Priority: reset, then bypass hit, then hardwired R0, then array.
module reg_file_rdport #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                                 rst,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic [DATA_W-1:0]                    data
);
  logic is_r0;
  logic hit;

  assign is_r0 = R0_ZERO && (addr == '0);
  // Forwarding never applies to a hardwired R0; the write would be discarded.
  assign hit   = BYPASS && wr_en && (wr_addr == addr) && !is_r0;

  always_comb begin
    data = regs[addr];
    if (rst)        data = '0;
    else if (hit)   data = wr_data;
    else if (is_r0) data = '0;
  end
endmodule

module reg_file #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit R0_ZERO = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int NREGS = 2**ADDR_W;
  localparam int NRD   = 2;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NRD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NRD-1:0][DATA_W-1:0]   rd_data;

  // R0 is never written when hardwired, so it holds its reset value of 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_en && !(R0_ZERO && (wr_addr == '0))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_addr  = {rd_addr2, rd_addr1};
  assign rd_data1 = rd_data[0];
  assign rd_data2 = rd_data[1];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    reg_file_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .R0_ZERO(R0_ZERO),
      .BYPASS (BYPASS)
    ) u_rd (
      .rst    (rst),
      .regs   (regs),
      .addr   (rd_addr[p]),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .data   (rd_data[p])
    );
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file. Two instances share all inputs:
//   ua: R0_ZERO=1, BYPASS=1 (defaults)
//   ub: R0_ZERO=0, BYPASS=0
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file ua (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(a_rd1),
    .rd_addr2(rd_addr2), .rd_data2(a_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  reg_file #(.R0_ZERO(1'b0), .BYPASS(1'b0)) ub (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(b_rd1),
    .rd_addr2(rd_addr2), .rd_data2(b_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Single write, returns 1 time unit after the edge with wr_en dropped.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd3;
    #12;
    checks++; if (a_rd1 !== 16'h0 || b_rd2 !== 16'h0) begin
      errors++; $display("FAIL reset_initial a_rd1=%h b_rd2=%h exp 0000", a_rd1, b_rd2);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wr(3'd3, 16'h1234);
    #1;
    checks++; if (a_rd1 !== 16'h1234 || b_rd2 !== 16'h1234) begin
      errors++; $display("FAIL reset_load_r3 a_rd1=%h b_rd2=%h exp 1234", a_rd1, b_rd2);
    end
    // Asynchronous pulse mid low phase, no clock edge needed.
    @(negedge clk); #2; rst = 1'b1; #1;
    checks++; if (a_rd1 !== 16'h0 || a_rd2 !== 16'h0 || b_rd1 !== 16'h0 || b_rd2 !== 16'h0) begin
      errors++; $display("FAIL reset_async a=%h/%h b=%h/%h exp 0000", a_rd1, a_rd2, b_rd1, b_rd2);
    end
    #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_rd1 !== 16'h0 || b_rd1 !== 16'h0) begin
      errors++; $display("FAIL reset_stays_clear a_rd1=%h b_rd1=%h exp 0000", a_rd1, b_rd1);
    end
  endtask

  task automatic test_write_read;
    wr(3'd1, 16'hA5A5);
    wr(3'd2, 16'h5A5A);
    rd_addr1 = 3'd1; rd_addr2 = 3'd2; #1;
    checks++; if (a_rd1 !== 16'hA5A5 || a_rd2 !== 16'h5A5A) begin
      errors++; $display("FAIL wr_rd_a rd1=%h rd2=%h exp a5a5/5a5a", a_rd1, a_rd2);
    end
    checks++; if (b_rd1 !== 16'hA5A5 || b_rd2 !== 16'h5A5A) begin
      errors++; $display("FAIL wr_rd_b rd1=%h rd2=%h exp a5a5/5a5a", b_rd1, b_rd2);
    end
    rd_addr2 = 3'd1; #1;
    checks++; if (a_rd2 !== 16'hA5A5 || a_rd1 !== a_rd2) begin
      errors++; $display("FAIL same_addr rd1=%h rd2=%h exp a5a5", a_rd1, a_rd2);
    end
  endtask

  task automatic test_r0;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; #1;
    checks++; if (a_rd1 !== 16'h0 || b_rd1 !== 16'h0) begin
      errors++; $display("FAIL r0_before_edge a=%h b=%h exp 0000", a_rd1, b_rd1);
    end
    @(posedge clk); #1; wr_en = 1'b0; #1;
    checks++; if (a_rd1 !== 16'h0 || a_rd2 !== 16'h0) begin
      errors++; $display("FAIL r0_hardwired rd1=%h rd2=%h exp 0000", a_rd1, a_rd2);
    end
    checks++; if (b_rd1 !== 16'hFFFF) begin
      errors++; $display("FAIL r0_normal b_rd1=%h exp ffff", b_rd1);
    end
  endtask

  task automatic test_bypass;
    wr(3'd4, 16'h0001);
    rd_addr1 = 3'd4; rd_addr2 = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00FF; #1;
    checks++; if (a_rd1 !== 16'h00FF || a_rd2 !== 16'h00FF) begin
      errors++; $display("FAIL bypass_on rd1=%h rd2=%h exp 00ff", a_rd1, a_rd2);
    end
    checks++; if (b_rd1 !== 16'h0001 || b_rd2 !== 16'h0001) begin
      errors++; $display("FAIL bypass_off rd1=%h rd2=%h exp 0001", b_rd1, b_rd2);
    end
    // Only port 1 matches the write address.
    rd_addr2 = 3'd1; #1;
    checks++; if (a_rd1 !== 16'h00FF || a_rd2 !== 16'hA5A5) begin
      errors++; $display("FAIL bypass_indep rd1=%h rd2=%h exp 00ff/a5a5", a_rd1, a_rd2);
    end
    @(posedge clk); #1; wr_en = 1'b0; rd_addr2 = 3'd4; #1;
    checks++; if (b_rd1 !== 16'h00FF || a_rd2 !== 16'h00FF) begin
      errors++; $display("FAIL bypass_after_edge b_rd1=%h a_rd2=%h exp 00ff", b_rd1, a_rd2);
    end
  endtask

  task automatic test_write_during_rst;
    rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; #1;
    checks++; if (a_rd1 !== 16'h0) begin
      errors++; $display("FAIL rst_no_bypass a_rd1=%h exp 0000", a_rd1);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rst = 1'b0; #1;
    checks++; if (a_rd1 !== 16'h0 || b_rd2 !== 16'h0) begin
      errors++; $display("FAIL rst_write_ignored a=%h b=%h exp 0000", a_rd1, b_rd2);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] e;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
    for (int i = 0; i < 8; i++) begin
      rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i); #1;
      e = 16'(16'h1111 * i);
      checks++; if (a_rd1 !== e || b_rd1 !== e) begin
        errors++; $display("FAIL sweep_p1 r%0d a=%h b=%h exp %h", i, a_rd1, b_rd1, e);
      end
      e = 16'(16'h1111 * (7 - i));
      checks++; if (a_rd2 !== e || b_rd2 !== e) begin
        errors++; $display("FAIL sweep_p2 r%0d a=%h b=%h exp %h", 7 - i, a_rd2, b_rd2, e);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_r0;
    test_bypass;
    test_write_during_rst;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
